// File: rtl/mono_data_tx_emu.sv
// Chip-side emulator of the LF-Monopix2 readout: hit queue, TOKEN/FREEZE
// bookkeeping and a READ-triggered MSB-first serialiser of 27-bit hit words.
module mono_data_tx_emu #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TX_DELAY   = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HIT_WR,
    input  logic [5:0] HIT_COL,
    input  logic [8:0] HIT_ROW,
    input  logic [5:0] HIT_LE,
    input  logic [5:0] HIT_TE,
    output logic       HIT_FULL,
    input  logic       FREEZE,
    input  logic       READ,
    output logic       TOKEN,
    output logic       DATA,
    output logic       BUSY,
    output logic [7:0] LOST_CNT
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);
    localparam logic [3:0]            DLY_INIT  = 4'(TX_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT
    } state_t;

    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [26:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   occ;
    logic [DEPTH_LOG2:0]   frozen_cnt;
    logic [7:0]            lost_cnt;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  avail;
    logic [26:0]           hit_word;

    logic                  read_ff;
    logic                  read_d;
    logic                  read_rise;
    logic                  frz_ff;
    logic                  frz_rise;
    logic                  frz_fall;

    state_t                state;
    logic [26:0]           shreg;
    logic [3:0]            dly;
    logic [4:0]            bitcnt;
    logic                  data_q;
    logic                  busy_q;
    logic                  token_q;

    assign hit_word  = {HIT_COL, gray6(HIT_LE), gray6(HIT_TE), HIT_ROW};
    assign full      = (occ == DEPTH_CNT);
    assign push      = HIT_WR & ~full;
    assign drop      = HIT_WR & full;
    // READ rise is taken between the two registered copies so the pop lands
    // on the first edge that sees the registered READ high.
    assign read_rise = read_ff & ~read_d;
    assign frz_rise  = FREEZE & ~frz_ff;
    assign frz_fall  = ~FREEZE & frz_ff;
    assign avail     = frz_ff ? (frozen_cnt != '0) : (occ != '0);
    assign pop       = (state == ST_IDLE) & read_rise & avail;

    assign HIT_FULL  = full;
    assign TOKEN     = token_q;
    assign DATA      = data_q;
    assign BUSY      = busy_q;
    assign LOST_CNT  = lost_cnt;

    // Register READ and FREEZE for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            read_ff <= 1'b0;
            read_d  <= 1'b0;
            frz_ff  <= 1'b0;
        end else begin
            read_ff <= READ;
            read_d  <= read_ff;
            frz_ff  <= FREEZE;
        end
    end

    // Queue storage; contents need no reset since occupancy gates all reads.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= hit_word;
        end
    end

    // Queue pointers, occupancy and the dropped-hit counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            lost_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
            if (drop && (lost_cnt != 8'hFF)) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

    // Freeze snapshot of the queue depth, counted down by pops while frozen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frozen_cnt <= '0;
        end else if (frz_rise) begin
            frozen_cnt <= occ - (pop ? OCC_ONE : '0);
        end else if (frz_fall) begin
            frozen_cnt <= '0;
        end else if (frz_ff && pop) begin
            frozen_cnt <= frozen_cnt - OCC_ONE;
        end
    end

    // TOKEN follows the frozen count during freeze, the live occupancy otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            token_q <= 1'b0;
        end else begin
            token_q <= frz_ff ? (frozen_cnt != '0) : (occ != '0);
        end
    end

    // Serialiser FSM with registered DATA and BUSY.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            dly    <= '0;
            bitcnt <= '0;
            data_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    data_q <= 1'b0;
                    if (pop) begin
                        shreg  <= mem[rd_ptr];
                        dly    <= DLY_INIT;
                        busy_q <= 1'b1;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The MSB leaves on the edge that ends the wait, so the
                    // first bit appears TX_DELAY edges after the pop.
                    if (dly == 4'd0) begin
                        data_q <= shreg[26];
                        bitcnt <= 5'd25;
                        state  <= ST_SHIFT;
                    end else begin
                        dly <= dly - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    data_q <= shreg[bitcnt];
                    if (bitcnt == 5'd0) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        bitcnt <= bitcnt - 5'd1;
                    end
                end
                default: begin
                    data_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mono_data_tx_emu.sv
// Directed bench for mono_data_tx_emu: queue, full/lost, freeze, empty read,
// ignored re-read and reset mid-shift.
module tb_mono_data_tx_emu;

    localparam int DL2 = 4;
    localparam int TXD = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       HIT_WR;
    logic [5:0] HIT_COL;
    logic [8:0] HIT_ROW;
    logic [5:0] HIT_LE;
    logic [5:0] HIT_TE;
    logic       HIT_FULL;
    logic       FREEZE;
    logic       READ;
    logic       TOKEN;
    logic       DATA;
    logic       BUSY;
    logic [7:0] LOST_CNT;

    int total = 0;
    int bad   = 0;

    mono_data_tx_emu #(.DEPTH_LOG2(DL2), .TX_DELAY(TXD)) dut (
        .CLK(CLK), .RST_N(RST_N), .HIT_WR(HIT_WR), .HIT_COL(HIT_COL),
        .HIT_ROW(HIT_ROW), .HIT_LE(HIT_LE), .HIT_TE(HIT_TE), .HIT_FULL(HIT_FULL),
        .FREEZE(FREEZE), .READ(READ), .TOKEN(TOKEN), .DATA(DATA), .BUSY(BUSY),
        .LOST_CNT(LOST_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [26:0] pack(input logic [5:0] c, input logic [8:0] r,
                                         input logic [5:0] le, input logic [5:0] te);
        return {c, le ^ (le >> 1), te ^ (te >> 1), r};
    endfunction

    // Hit pattern used by the multi-hit scenarios.
    function automatic logic [26:0] hit_n(input int i);
        return pack(6'(i), 9'(i * 7 + 1), 6'(i * 5), 6'(63 - i));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_hit(input logic [5:0] c, input logic [8:0] r,
                             input logic [5:0] le, input logic [5:0] te);
        HIT_COL = c; HIT_ROW = r; HIT_LE = le; HIT_TE = te; HIT_WR = 1'b1;
        tick();
        HIT_WR = 1'b0;
    endtask

    task automatic write_n(input int i);
        write_hit(6'(i), 9'(i * 7 + 1), 6'(i * 5), 6'(63 - i));
    endtask

    task automatic apply_reset();
        RST_N = 1'b0; HIT_WR = 1'b0; FREEZE = 1'b0; READ = 1'b0;
        HIT_COL = '0; HIT_ROW = '0; HIT_LE = '0; HIT_TE = '0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Two-cycle READ pulse, then collect 27 DATA bits at their scheduled slots.
    // reread_at >= 0 raises READ again for 2 cycles once that many bits have passed.
    task automatic do_read(input int reread_at, output logic [26:0] word,
                           output logic busy_seen, output logic early, output logic tail);
        word = '0;
        early = 1'b0;
        READ = 1'b1;
        tick();
        tick();
        READ = 1'b0;
        busy_seen = BUSY;
        for (int k = 1; k < TXD; k++) begin
            tick();
            early = early | DATA;
        end
        for (int b = 26; b >= 0; b--) begin
            tick();
            word[b] = DATA;
            if ((26 - b) == reread_at) READ = 1'b1;
            if ((26 - b) == reread_at + 2) READ = 1'b0;
        end
        tick();
        tail = DATA | BUSY;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; HIT_WR = 1'b0; FREEZE = 1'b0; READ = 1'b0;
        HIT_COL = '0; HIT_ROW = '0; HIT_LE = '0; HIT_TE = '0;
        tick();
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL rst_token: got %b want 0", TOKEN); end
        total++; if (DATA !== 1'b0) begin bad++; $display("FAIL rst_data: got %b want 0", DATA); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        total++; if (HIT_FULL !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", HIT_FULL); end
        total++; if (LOST_CNT !== 8'd0) begin bad++; $display("FAIL rst_lost: got %0d want 0", LOST_CNT); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single_hit();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        write_hit(6'd3, 9'd5, 6'd37, 6'd10);
        tick();
        total++; if (TOKEN !== 1'b1) begin bad++; $display("FAIL one_token_up: got %b want 1", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== 27'b000011_110111_001111_000000101) begin bad++; $display("FAIL one_word: got %b want 000011110111001111000000101", w); end
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL one_busy: got %b want 1", bs); end
        total++; if (ea !== 1'b0) begin bad++; $display("FAIL one_early_data: got %b want 0", ea); end
        total++; if (tl !== 1'b0) begin bad++; $display("FAIL one_tail: got %b want 0", tl); end
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL one_token_down: got %b want 0", TOKEN); end
    endtask

    task automatic test_full_lost();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        for (int i = 0; i < (1 << DL2) + 3; i++) begin
            write_n(i);
            if (i == (1 << DL2) - 2) begin
                total++; if (HIT_FULL !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", HIT_FULL); end
            end
            if (i == (1 << DL2) - 1) begin
                total++; if (HIT_FULL !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", HIT_FULL); end
            end
        end
        total++; if (LOST_CNT !== 8'd3) begin bad++; $display("FAIL lost_cnt: got %0d want 3", LOST_CNT); end
        for (int j = 0; j < 3; j++) begin
            do_read(-10, w, bs, ea, tl);
            total++; if (w !== hit_n(j)) begin bad++; $display("FAIL full_word%0d: got %h want %h", j, w, hit_n(j)); end
            if (j == 0) begin
                total++; if (HIT_FULL !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0", HIT_FULL); end
            end
        end
        total++; if (LOST_CNT !== 8'd3) begin bad++; $display("FAIL lost_hold: got %0d want 3", LOST_CNT); end
    endtask

    task automatic test_freeze();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        write_n(0); write_n(1);
        tick();
        FREEZE = 1'b1;
        tick();
        write_n(2); write_n(3); write_n(4);
        tick();
        total++; if (TOKEN !== 1'b1) begin bad++; $display("FAIL frz_token_start: got %b want 1", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== hit_n(0)) begin bad++; $display("FAIL frz_word0: got %h want %h", w, hit_n(0)); end
        total++; if (TOKEN !== 1'b1) begin bad++; $display("FAIL frz_token_mid: got %b want 1", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== hit_n(1)) begin bad++; $display("FAIL frz_word1: got %h want %h", w, hit_n(1)); end
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL frz_token_drop: got %b want 0", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL frz_no_pop_busy: got %b want 0", bs); end
        FREEZE = 1'b0;
        tick(); tick(); tick();
        total++; if (TOKEN !== 1'b1) begin bad++; $display("FAIL frz_token_after: got %b want 1", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== hit_n(2)) begin bad++; $display("FAIL frz_word2: got %h want %h", w, hit_n(2)); end
    endtask

    task automatic test_empty_read();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== 27'd0) begin bad++; $display("FAIL empty_data: got %h want 0", w); end
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL empty_busy: got %b want 0", bs); end
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL empty_token: got %b want 0", TOKEN); end
        write_n(9);
        tick();
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== hit_n(9)) begin bad++; $display("FAIL empty_then_word: got %h want %h", w, hit_n(9)); end
    endtask

    task automatic test_back_to_back();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        write_n(5); write_n(6);
        tick();
        do_read(5, w, bs, ea, tl);
        total++; if (w !== hit_n(5)) begin bad++; $display("FAIL b2b_word0: got %h want %h", w, hit_n(5)); end
        total++; if (tl !== 1'b0) begin bad++; $display("FAIL b2b_tail: got %b want 0", tl); end
        total++; if (TOKEN !== 1'b1) begin bad++; $display("FAIL b2b_token: got %b want 1", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (w !== hit_n(6)) begin bad++; $display("FAIL b2b_word1: got %h want %h", w, hit_n(6)); end
        do_read(-10, w, bs, ea, tl);
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL b2b_empty_busy: got %b want 0", bs); end
    endtask

    task automatic test_reset_mid_shift();
        logic [26:0] w; logic bs, ea, tl;
        apply_reset();
        write_hit(6'd3, 9'd5, 6'd37, 6'd10);
        tick();
        READ = 1'b1;
        tick(); tick();
        READ = 1'b0;
        for (int k = 0; k < TXD; k++) tick();
        for (int k = 0; k < 16; k++) tick();
        total++; if (DATA !== 1'b1) begin bad++; $display("FAIL mid_bit10: got %b want 1", DATA); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", BUSY); end
        RST_N = 1'b0;
        #1;
        total++; if (DATA !== 1'b0) begin bad++; $display("FAIL mid_rst_data: got %b want 0", DATA); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", BUSY); end
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL mid_rst_token: got %b want 0", TOKEN); end
        tick(); tick();
        RST_N = 1'b1;
        tick(); tick();
        total++; if (TOKEN !== 1'b0) begin bad++; $display("FAIL mid_post_token: got %b want 0", TOKEN); end
        do_read(-10, w, bs, ea, tl);
        total++; if (bs !== 1'b0) begin bad++; $display("FAIL mid_post_busy: got %b want 0", bs); end
        total++; if (w !== 27'd0) begin bad++; $display("FAIL mid_post_data: got %h want 0", w); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_full_lost();
        test_freeze();
        test_empty_read();
        test_back_to_back();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
